reset_sequencer: RTL and testbench

Sequences the Propeller core reset from three sources: PLL lock, the host serial-port RTS line, and the board reset button. It runs in the clock_160 domain and its output drives the core's active-low reset input, p1v inp_resn. It replaces a purely combinational async OR of the reset sources with the following:
- Synchronized and glitch-filtered reset requests.
- A guaranteed minimum reset pulse width.
- A PLL-lock holdoff.
- Recording of the reset cause and a count of reset events.

---
 rtl/p1v_pkg.sv | 27 ++
 rtl/reset_sequencer_sync_filter.sv | 41 ++++
 rtl/reset_sequencer.sv | 137 +++++++++++++
 tb/tb_reset_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/p1v_pkg.sv
// Shared types for the Propeller core reset sequencer: FSM states and
// reset-cause encodings.
package p1v_pkg;

  typedef enum logic [1:0] {
    S_LOCKWAIT = 2'd0,
    S_ASSERT   = 2'd1,
    S_HOLD     = 2'd2,
    S_RUN      = 2'd3
  } seq_state_t;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_RTS  = 2'd1;
  localparam logic [1:0] CAUSE_BTN  = 2'd2;
  localparam logic [1:0] CAUSE_BOTH = 2'd3;

  // Encodings are bitwise {btn, rts}, so causes can be accumulated with OR.
  function automatic logic [1:0] cause_of(input logic btn, input logic rts);
    case ({btn, rts})
      2'b01:   cause_of = CAUSE_RTS;
      2'b10:   cause_of = CAUSE_BTN;
      2'b11:   cause_of = CAUSE_BOTH;
      default: cause_of = CAUSE_POR;
    endcase
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_filter.sv
// Two-flop synchronizer followed by a glitch filter: the filtered output only
// follows the synchronized input after FILTER_CYCLES stable samples.
module sync_filter #(
  parameter int   FILTER_CYCLES = 16,
  parameter logic RESET_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Any sample that agrees with the filtered value restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= RESET_VAL;
      sync_q2  <= RESET_VAL;
      filtered <= RESET_VAL;
      cnt      <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == filtered) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filtered <= sync_q2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Propeller core reset sequencer: filters RTS/button requests, waits for a
// stable PLL lock, stretches the reset pulse and records cause and count.
module reset_sequencer
  import p1v_pkg::*;
#(
  parameter int FILTER_CYCLES    = 16,
  parameter int PULSE_CYCLES     = 1600,
  parameter int LOCK_HOLD_CYCLES = 16000
) (
  input  logic       clock_160,
  input  logic       inp_resn,
  input  logic       pll_locked,
  input  logic       rts_n,
  input  logic       button_n,
  output logic       core_resn,
  output logic [1:0] reset_cause,
  output logic [7:0] reset_count,
  output logic       busy
);

  localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);
  localparam int LOCK_W  = $clog2(LOCK_HOLD_CYCLES + 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_HOLD_CYCLES - 1);

  seq_state_t         state, state_nxt;
  logic [1:0]         cause_nxt;
  logic [PULSE_W-1:0] pulse_cnt, pulse_nxt;
  logic [LOCK_W-1:0]  lock_cnt, lock_nxt;
  logic               lock_q1, lock_s;
  logic               rts_f, btn_f;
  logic               req_rts, req_btn, req;

  sync_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VAL(1'b1)) u_rts_filter (
    .clk      (clock_160),
    .rst_n    (inp_resn),
    .raw      (rts_n),
    .filtered (rts_f)
  );

  sync_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VAL(1'b1)) u_btn_filter (
    .clk      (clock_160),
    .rst_n    (inp_resn),
    .raw      (button_n),
    .filtered (btn_f)
  );

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      lock_q1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_q1 <= pll_locked;
      lock_s  <= lock_q1;
    end
  end

  assign req_rts = ~rts_f;
  assign req_btn = ~btn_f;
  assign req     = req_rts | req_btn;
  assign busy    = (state != S_RUN);

  // Lock loss outranks every request; otherwise the state decides.
  always_comb begin
    state_nxt = state;
    cause_nxt = reset_cause;
    pulse_nxt = pulse_cnt;
    lock_nxt  = '0;
    if (state != S_LOCKWAIT && !lock_s) begin
      state_nxt = S_LOCKWAIT;
      cause_nxt = CAUSE_POR;
    end else begin
      case (state)
        S_LOCKWAIT: begin
          if (!lock_s) begin
            lock_nxt = '0;
          end else if (lock_cnt == LOCK_LAST) begin
            if (req) begin
              state_nxt = S_ASSERT;
              pulse_nxt = PULSE_LAST;
              cause_nxt = reset_cause | cause_of(req_btn, req_rts);
            end else begin
              state_nxt = S_RUN;
            end
          end else begin
            lock_nxt = lock_cnt + 1'b1;
          end
        end
        S_ASSERT: begin
          pulse_nxt = PULSE_LAST;
          cause_nxt = reset_cause | cause_of(req_btn, req_rts);
          if (!req) state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (req) begin
            state_nxt = S_ASSERT;
            pulse_nxt = PULSE_LAST;
            cause_nxt = reset_cause | cause_of(req_btn, req_rts);
          end else if (pulse_cnt == '0) begin
            state_nxt = S_RUN;
          end else begin
            pulse_nxt = pulse_cnt - 1'b1;
          end
        end
        S_RUN: begin
          if (req) begin
            state_nxt = S_ASSERT;
            pulse_nxt = PULSE_LAST;
            cause_nxt = cause_of(req_btn, req_rts);
          end
        end
        default: state_nxt = S_LOCKWAIT;
      endcase
    end
  end

  // core_resn follows the next state so it changes on the entering edge itself.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      state       <= S_LOCKWAIT;
      core_resn   <= 1'b0;
      reset_cause <= CAUSE_POR;
      reset_count <= '0;
      pulse_cnt   <= '0;
      lock_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      core_resn   <= (state_nxt == S_RUN);
      reset_cause <= cause_nxt;
      pulse_cnt   <= pulse_nxt;
      lock_cnt    <= lock_nxt;
      if (state_nxt == S_RUN && state != S_RUN && reset_count != 8'hFF)
        reset_count <= reset_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small timing parameters; inputs are
// driven and outputs sampled on the falling clock edge.
module tb_reset_sequencer;
  import p1v_pkg::*;

  logic       clock_160;
  logic       inp_resn;
  logic       pll_locked;
  logic       rts_n;
  logic       button_n;
  logic       core_resn;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int fall_events = 0;
  int falls_before;
  int edges;

  reset_sequencer #(
    .FILTER_CYCLES    (4),
    .PULSE_CYCLES     (8),
    .LOCK_HOLD_CYCLES (10)
  ) dut (
    .clock_160   (clock_160),
    .inp_resn    (inp_resn),
    .pll_locked  (pll_locked),
    .rts_n       (rts_n),
    .button_n    (button_n),
    .core_resn   (core_resn),
    .reset_cause (reset_cause),
    .reset_count (reset_count),
    .busy        (busy)
  );

  initial clock_160 = 1'b0;
  always #5 clock_160 = ~clock_160;

  always @(negedge core_resn) fall_events <= fall_events + 1;

  task automatic check_output(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock_160);
  endtask

  // Counts rising clock edges until core_resn reaches target, bounded by max_edges.
  task automatic measure_edges(input logic target, input int max_edges, output int n);
    n = 0;
    do begin
      @(posedge clock_160);
      n++;
      @(negedge clock_160);
    end while (core_resn !== target && n < max_edges);
  endtask

  task automatic apply_stimulus(input logic rts_v, input logic btn_v, input logic lock_v);
    rts_n      = rts_v;
    button_n   = btn_v;
    pll_locked = lock_v;
  endtask

  initial begin
    inp_resn = 1'b0;
    apply_stimulus(1'b1, 1'b1, 1'b1);
    wait_cycles(3);
    check_output("por_core_resn", 32'(core_resn), 0);
    check_output("por_cause", 32'(reset_cause), 32'(CAUSE_POR));
    check_output("por_count", 32'(reset_count), 0);
    check_output("por_busy", 32'(busy), 1);

    // Power-up: 2 sync edges plus 10 lock-hold edges.
    inp_resn = 1'b1;
    measure_edges(1'b1, 50, edges);
    check_output("pwrup_rise_edges", edges, 12);
    check_output("pwrup_count", 32'(reset_count), 1);
    check_output("pwrup_cause", 32'(reset_cause), 32'(CAUSE_POR));
    check_output("pwrup_busy", 32'(busy), 0);

    // RTS pulse: filter latency 6 then the FSM entry edge; release adds 8 + 1.
    wait_cycles(5);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    measure_edges(1'b0, 50, edges);
    check_output("rts_fall_edges", edges, 7);
    check_output("rts_busy_low", 32'(busy), 1);
    wait_cycles(13);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    measure_edges(1'b1, 50, edges);
    check_output("rts_rise_edges", edges, 15);
    check_output("rts_cause", 32'(reset_cause), 32'(CAUSE_RTS));
    check_output("rts_count", 32'(reset_count), 2);

    // Glitch rejection: 3-cycle pulses are shorter than the filter window.
    wait_cycles(5);
    falls_before = fall_events;
    apply_stimulus(1'b0, 1'b1, 1'b1);
    wait_cycles(3);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    wait_cycles(10);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    wait_cycles(3);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    wait_cycles(10);
    check_output("glitch_core_resn", 32'(core_resn), 1);
    check_output("glitch_falls", fall_events - falls_before, 0);
    check_output("glitch_count", 32'(reset_count), 2);

    // Overlapping button then RTS requests form a single reset event.
    falls_before = fall_events;
    apply_stimulus(1'b1, 1'b0, 1'b1);
    wait_cycles(10);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    wait_cycles(10);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    wait_cycles(10);
    check_output("overlap_held_low", 32'(core_resn), 0);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    measure_edges(1'b1, 50, edges);
    check_output("overlap_rise_edges", edges, 15);
    check_output("overlap_cause", 32'(reset_cause), 32'(CAUSE_BOTH));
    check_output("overlap_count", 32'(reset_count), 3);
    check_output("overlap_falls", fall_events - falls_before, 1);

    // Re-request while holding: filtered request returns 5 edges into the hold.
    wait_cycles(5);
    falls_before = fall_events;
    apply_stimulus(1'b0, 1'b1, 1'b1);
    wait_cycles(20);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    wait_cycles(5);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    wait_cycles(10);
    check_output("rereq_still_low", 32'(core_resn), 0);
    check_output("rereq_busy", 32'(busy), 1);
    wait_cycles(5);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    measure_edges(1'b1, 50, edges);
    check_output("rereq_rise_edges", edges, 15);
    check_output("rereq_count", 32'(reset_count), 4);
    check_output("rereq_falls", fall_events - falls_before, 1);
    check_output("rereq_cause", 32'(reset_cause), 32'(CAUSE_RTS));

    // Lock loss in the hold phase with the button pressed.
    wait_cycles(5);
    falls_before = fall_events;
    apply_stimulus(1'b0, 1'b1, 1'b1);
    wait_cycles(20);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    wait_cycles(8);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    wait_cycles(5);
    check_output("lockloss_cause", 32'(reset_cause), 32'(CAUSE_POR));
    check_output("lockloss_core_resn", 32'(core_resn), 0);
    check_output("lockloss_busy", 32'(busy), 1);
    wait_cycles(10);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    wait_cycles(30);
    check_output("relock_core_resn", 32'(core_resn), 0);
    check_output("relock_busy", 32'(busy), 1);
    check_output("relock_cause", 32'(reset_cause), 32'(CAUSE_BTN));
    check_output("relock_count", 32'(reset_count), 4);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    measure_edges(1'b1, 50, edges);
    check_output("relock_rise_edges", edges, 15);
    check_output("relock_final_count", 32'(reset_count), 5);
    check_output("lockloss_falls", fall_events - falls_before, 1);

    // Asynchronous reset in the middle of operation clears everything.
    wait_cycles(3);
    #2 inp_resn = 1'b0;
    #1;
    check_output("areset_core_resn", 32'(core_resn), 0);
    check_output("areset_count", 32'(reset_count), 0);
    check_output("areset_cause", 32'(reset_cause), 32'(CAUSE_POR));
    check_output("areset_busy", 32'(busy), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
